// File: rtl/glb_pkg.sv
// Types and constants shared by the GLB SRAM banks and their controllers.
package glb_pkg;
  typedef enum logic {GLB_IDLE = 1'b0, GLB_CLEAR = 1'b1} glb_bank_state_t;
  localparam int RSP_FIFO_DEPTH = 2;
endpackage

// File: rtl/glb_rsp_fifo.sv
// Two-entry ordered read-response buffer; the head word stays stable while the consumer stalls.
module glb_rsp_fifo
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            occ
);
  localparam logic [1:0] FULL = 2'(RSP_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push && pop) begin
      // Occupancy unchanged: the tail (or the incoming word) moves up to the head.
      if (occ_q == 2'd1) begin
        head_d = push_data;
      end else begin
        head_d = tail_q;
        tail_d = push_data;
      end
    end else if (pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end else if (push) begin
      if (occ_q == 2'd0) head_d = push_data;
      else               tail_d = push_data;
      occ_d = occ_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign rsp_valid = (occ_q != 2'd0);
  assign rsp_data  = head_q;
  assign occ       = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ_q == FULL));
endmodule

// File: rtl/glb_sram_bank.sv
// GLB SRAM bank: simple-dual-port array with handshaked ports, write-first forwarding,
// a 2-deep backpressured read-response path and a hardware zero-clear sweep.
module glb_sram_bank
  import glb_pkg::*;
#(
  parameter int    DATA_WIDTH = 16,
  parameter int    DEPTH      = 64,
  parameter int    ADDR       = $clog2(DEPTH),
  parameter string RAM_STYLE  = "block"
) (
  input  logic                  core_clk,
  input  logic                  core_rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR-1:0]       rd_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done
);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  if (DEPTH < 2 || RAM_STYLE == "") begin : g_bad_cfg
    $error("glb_sram_bank: DEPTH must be >= 2 and RAM_STYLE must be non-empty");
  end

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  glb_bank_state_t       state_q, state_d;
  logic [ADDR-1:0]       sweep_cnt_q, sweep_cnt_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  busy_q, busy_d;
  logic                  clear_done_q, clear_done_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_fire, rd_fire, rsp_pop, wr_in_range, rd_in_range;
  logic                  mem_we;
  logic [ADDR-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            occ;
  logic [2:0]            rd_load;

  assign wr_in_range = (int'(wr_addr) < DEPTH);
  assign rd_in_range = (int'(rd_addr) < DEPTH);
  assign wr_fire     = wr_valid && wr_ready_q;
  assign rd_fire     = rd_req_valid && rd_req_ready;
  assign rsp_pop     = rd_rsp_valid && rd_rsp_ready;

  // wr_ready_q doubles as "IDLE and out of reset"; the pop term lets a stalled-free
  // consumer keep one read per cycle flowing.
  assign rd_load      = 3'(occ) + 3'(inflight_q) - 3'(rsp_pop);
  assign rd_req_ready = wr_ready_q && (rd_load < 3'(RSP_FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    clear_done_d = 1'b0;
    case (state_q)
      GLB_IDLE: begin
        if (clear_req) begin
          state_d     = GLB_CLEAR;
          sweep_cnt_d = '0;
        end
      end
      GLB_CLEAR: begin
        if (sweep_cnt_q == LAST_ADDR) begin
          state_d      = GLB_IDLE;
          clear_done_d = 1'b1;
        end else begin
          sweep_cnt_d = sweep_cnt_q + ADDR'(1);
        end
      end
      default: state_d = GLB_IDLE;
    endcase
    wr_ready_d = (state_d == GLB_IDLE);
    busy_d     = (state_d == GLB_CLEAR);
    inflight_d = rd_fire;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == GLB_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt_q;
      mem_wdata = '0;
    end else if (wr_fire && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Write-first: a same-edge write to the read address is captured instead of the old word.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) rd_data_d = (wr_fire && wr_addr == rd_addr) ? wr_data : mem_q[rd_addr];
  end

  always_ff @(posedge core_clk) begin
    if (mem_we)  mem_q[mem_waddr] <= mem_wdata;
    if (rd_fire) rd_data_q        <= rd_data_d;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q      <= GLB_IDLE;
      sweep_cnt_q  <= '0;
      wr_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      wr_ready_q   <= wr_ready_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
      inflight_q   <= inflight_d;
    end
  end

  glb_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk       (core_clk),
    .rst_n     (core_rst_n),
    .push      (inflight_q),
    .push_data (rd_data_q),
    .pop       (rsp_pop),
    .rsp_valid (rd_rsp_valid),
    .rsp_data  (rd_rsp_data),
    .occ       (occ)
  );

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;

  a_wr_in_range: assert property (@(posedge core_clk) disable iff (!core_rst_n)
    wr_fire |-> wr_in_range);
  a_rd_in_range: assert property (@(posedge core_clk) disable iff (!core_rst_n)
    rd_fire |-> rd_in_range);
endmodule

// File: doc/glb_sram_bank.md
Name: glb_sram_bank

Overview:
- Parametrised global-buffer SRAM bank for the GLB unit, replacing the bare one-port RAM.
- Holds one simple-dual-port array (one write port, one read port) with a valid/ready handshake on both ports and a backpressured read-response path.
- Adds same-address write-first forwarding and a hardware clear sweep, so ifmap/filter/psum GLB controllers can zero a bank between layers without host writes.
- Sits between the GLB controllers and the PE-array NoC buffers.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- DEPTH, 64, words per bank; any value ≥ 2, need not be a power of 2.
- ADDR, $clog2(DEPTH), address width (derived; do not override).
- RAM_STYLE, "block", synthesis ram_style attribute applied to the array.

Ports:
- core_clk  in  1  single clock; all logic on rising edge.
- core_rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted when high together with wr_valid.
- wr_addr  in  ADDR  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accept.
- rd_addr  in  ADDR  read address.
- rd_rsp_valid  out  1  read data valid.
- rd_rsp_ready  in  1  consumer accepts rd_rsp_data.
- rd_rsp_data  out  DATA_WIDTH  read data, in request order.
- clear_req  in  1  single-cycle pulse: start zero sweep.
- busy  out  1  high while in CLEAR.
- clear_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset values: wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, busy=0, clear_done=0.
- Reset also clears the state (to IDLE), the sweep counter, the in-flight flag and the response buffer. Array contents are not reset.
- States:
  - IDLE: wr_ready=1.
  - CLEAR: wr_ready=0, rd_req_ready=0, busy=1.
- IDLE→CLEAR on clear_req. Requests handshaken in that same cycle are still executed.
- In CLEAR, write 0 to address sweep_cnt, one address per cycle from 0 to DEPTH-1. The sweep takes exactly DEPTH cycles.
- After the last address write: clear_done=1 for one cycle, then IDLE. clear_req while in CLEAR is ignored.
- Write: on wr_valid && wr_ready, mem[wr_addr] ← wr_data at that edge.
- Read: on rd_req_valid && rd_req_ready, the array is read at that edge. Data enters the 2-entry response FIFO on the next edge.
  - rd_rsp_valid is therefore high at the earliest 1 cycle after the request.
- Same-cycle write and read to the same address: the response returns the new wr_data (write-first, via a registered bypass).
- rd_req_ready = (state==IDLE) && (occ + inflight − pop < 2), where pop = rd_rsp_valid && rd_rsp_ready.
  - This is a deliberate combinational path from rd_rsp_ready to rd_req_ready.
  - It sustains 1 read per cycle while the consumer is always ready.
- Response FIFO: 2 entries, strict order, and data holds stable while rd_rsp_valid && !rd_rsp_ready.
  - A simultaneous push and pop keeps occupancy unchanged.
  - The FIFO never overflows by construction. An assertion must fire if a push happens with occ==2 and no pop.
- A read accepted in the same cycle as clear_req returns pre-clear data.
- Reads in flight at entry to CLEAR still drain through the response FIFO during the sweep.
- Out-of-range addresses (≥ DEPTH, when DEPTH is not a power of 2): writes are dropped and reads return 0. These are flagged by an assertion.
- Reset asserted mid-sweep: the sweep is abandoned and no clear_done is pulsed. Contents are partially cleared and are undefined to users.

Decomposition:
- glb_pkg: typedef enum logic {GLB_IDLE, GLB_CLEAR} glb_bank_state_t, plus the localparam RSP_FIFO_DEPTH=2 shared with the other GLB banks.
- One sub-module, glb_rsp_fifo: 2-entry ordered FIFO, parametrised on DATA_WIDTH, outputs occ.
- The array, bypass, in-flight flag and FSM stay in glb_sram_bank.

Test Plan:
1. Write/read: write addr 5 = 0xBEEF, then read addr 5 with rd_rsp_ready=1 → rd_rsp_valid one cycle after acceptance, data 0xBEEF.
2. Streaming: write 0..63 = addr*3, then 64 back-to-back reads with rd_rsp_ready=1 → rd_req_ready never drops, 64 ordered responses, 1 per cycle.
3. Backpressure: 4 reads issued while rd_rsp_ready=0.
   - rd_req_ready drops after 2 accepts.
   - Data holds stable.
   - Releasing ready delivers all 4 in order, with no loss or duplication.
4. Collision: mem[9]=0x1111; same-cycle write 9=0x2222 and read 9 → response 0x2222; a later read of 9 also returns 0x2222.
5. Clear: fill all addresses with 0xFFFF, pulse clear_req.
   - busy=1 for 64 cycles, ready signals are low throughout, and clear_done pulses once.
   - Reads of all 64 addresses then return 0.
6. Reset mid-sweep: assert core_rst_n=0 at sweep cycle 20 → all outputs go to reset values immediately, with no clear_done; normal write/read works after release.
